// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single write port of the 16-entry register bank between two
//   writeback requesters: the ALU (requester 0) and the load unit
//   (requester 1). Arbitration is round-robin using valid/ready handshakes.
//   The block also keeps a pending-write scoreboard so the issue stage can
//   spot read-after-write hazards on both of its read addresses.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req0_valid/ready/addr/data   ALU writeback handshake
//   req1_valid/ready/addr/data   load-unit writeback handshake
//   wb_hold                  blocks every grant while high
//   rf_we, rf_waddr, rf_wdata    registered bank write port
//   mark_valid, mark_addr    issue stage declares a new outstanding producer
//   chk_addr0, chk_addr1     read addresses to check for hazards
//   hazard0, hazard1         combinational hazard flags for those addresses
//   pending                  full scoreboard bit vector
//   err_unmarked             sticky flag: a commit hit a non-pending register
module regfile_wb_arbiter #(
  parameter int WIDTH = 20,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AW-1:0]        req0_addr,
  input  logic [WIDTH-1:0]     req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AW-1:0]        req1_addr,
  input  logic [WIDTH-1:0]     req1_data,
  input  logic                 wb_hold,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [WIDTH-1:0]     rf_wdata,
  input  logic                 mark_valid,
  input  logic [AW-1:0]        mark_addr,
  input  logic [AW-1:0]        chk_addr0,
  input  logic [AW-1:0]        chk_addr1,
  output logic                 hazard0,
  output logic                 hazard1,
  output logic [(1<<AW)-1:0]   pending,
  output logic                 err_unmarked
);

  localparam int DEPTH = 1 << AW;

  // Round-robin priority: names the requester that wins when both are valid.
  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } pri_t;

  pri_t             pri;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [DEPTH-1:0] pending_next;

  // Grant logic. Ready is never raised during reset or hold, so no handshake
  // can complete then. Requester 0 wins unless requester 1 is also valid and
  // currently holds priority; at most one grant is ever high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !wb_hold) begin
      if (req0_valid && (!req1_valid || pri == PRI_REQ0)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  // Scoreboard next state. The clear is applied before the set so a new
  // producer marked in the same cycle as a commit to that register survives.
  always_comb begin
    pending_next = pending;
    if (rf_we) begin
      pending_next[rf_waddr] = 1'b0;
    end
    if (mark_valid) begin
      pending_next[mark_addr] = 1'b1;
    end
  end

  // The bank still holds the old value during the rf_we cycle, so the
  // pending bit (and therefore the hazard) stays up until the cycle after.
  assign hazard0 = pending[chk_addr0];
  assign hazard1 = pending[chk_addr1];

  // Registered write port, priority pointer, scoreboard and error flag.
  // A write accepted just before reset is dropped because rf_we is forced
  // low by the reset edge; address/data only move on an accept so they hold
  // their last value while rf_we is low. err_unmarked looks at the scoreboard
  // before this edge's update, so a same-cycle re-mark does not hide an
  // unmarked commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      pri          <= PRI_REQ0;
      pending      <= '0;
      err_unmarked <= 1'b0;
    end else begin
      rf_we <= accept;
      if (grant0) begin
        rf_waddr <= req0_addr;
        rf_wdata <= req0_data;
      end else if (grant1) begin
        rf_waddr <= req1_addr;
        rf_wdata <= req1_data;
      end
      if (accept) begin
        pri <= grant0 ? PRI_REQ1 : PRI_REQ0;
      end
      pending <= pending_next;
      if (rf_we && !pending[rf_waddr]) begin
        err_unmarked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Purpose:
//   Self-checking bench for regfile_wb_arbiter. Each scenario task drives
//   the handshakes, pushes the write it expects the bank port to show onto
//   a scoreboard queue, and pops/compares when rf_we appears. Inputs change
//   1 time unit after the rising edge; outputs are sampled on the falling
//   edge.
//
// Ports:
//   none (top-level bench)
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 20;
  localparam int AW    = 4;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic               clk;
  logic               rst;
  logic               req0_valid;
  logic               req0_ready;
  logic [AW-1:0]      req0_addr;
  logic [WIDTH-1:0]   req0_data;
  logic               req1_valid;
  logic               req1_ready;
  logic [AW-1:0]      req1_addr;
  logic [WIDTH-1:0]   req1_data;
  logic               wb_hold;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [WIDTH-1:0]   rf_wdata;
  logic               mark_valid;
  logic [AW-1:0]      mark_addr;
  logic [AW-1:0]      chk_addr0;
  logic [AW-1:0]      chk_addr1;
  logic               hazard0;
  logic               hazard1;
  logic [(1<<AW)-1:0] pending;
  logic               err_unmarked;

  int  checks;
  int  errors;
  wr_t exp_q[$];
  wr_t exp_w;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .hazard0(hazard0), .hazard1(hazard1),
    .pending(pending), .err_unmarked(err_unmarked)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset pulse; clears the model's view as well.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 20'h00abc;
    chk_addr0 = 4'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
      end
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_we: got %b want 0", rf_we);
      end
      checks++;
      if (pending !== '0 || err_unmarked !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state: pending=%h err=%b want 0/0", pending, err_unmarked);
      end
      step();
    end
    rst = 1'b0;
    mark_valid = 1'b1; mark_addr = 4'd1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_accept: got %b%b want 10", req0_ready, req1_ready);
    end
    exp_q.push_back('{addr: req0_addr, data: req0_data});
    step();
    req0_valid = 1'b0; mark_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL first_commit: rf_we=%b queued=%0d want 1/1", rf_we, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (rf_waddr !== exp_w.addr || rf_wdata !== exp_w.data) begin
        errors++;
        $display("[TB] FAIL first_commit: got %0d=%h want %0d=%h", rf_waddr, rf_wdata, exp_w.addr, exp_w.data);
      end
    end
    checks++;
    if (hazard0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_hazard: got %b want 1", hazard0);
    end
    step();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || hazard0 !== 1'b0 || err_unmarked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_after: we=%b hz=%b err=%b want 0/0/0", rf_we, hazard0, err_unmarked);
    end
    step();
  endtask

  task automatic test_single_write();
    mark_valid = 1'b1; mark_addr = 4'd5; chk_addr0 = 4'd5; chk_addr1 = 4'd5;
    step();
    mark_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 20'h12345;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || hazard0 !== 1'b1 || hazard1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_accept: rdy=%b hz=%b%b want 1/11", req0_ready, hazard0, hazard1);
    end
    exp_q.push_back('{addr: req0_addr, data: req0_data});
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL single_commit: rf_we=%b queued=%0d want 1/1", rf_we, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (rf_waddr !== exp_w.addr || rf_wdata !== exp_w.data) begin
        errors++;
        $display("[TB] FAIL single_commit: got %0d=%h want %0d=%h", rf_waddr, rf_wdata, exp_w.addr, exp_w.data);
      end
    end
    checks++;
    if (hazard0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_hazard_hold: got %b want 1", hazard0);
    end
    step();
    @(negedge clk);
    checks++;
    if (hazard0 !== 1'b0 || pending[5] !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_hazard_drop: hz=%b p5=%b we=%b want 0/0/0", hazard0, pending[5], rf_we);
    end
    step();
  endtask

  task automatic test_hold_and_fairness();
    logic exp0;
    do_reset();
    wb_hold = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 20'ha0000;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 20'hb0000;
    for (int i = 0; i < 3; i++) begin
      mark_valid = (i < 2);
      mark_addr  = (i == 0) ? 4'd1 : 4'd2;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rf_we !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_%0d: rdy=%b%b we=%b want 00/0", i, req0_ready, req1_ready, rf_we);
      end
      step();
    end
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mark_valid = (i == 1 || i == 2);
      mark_addr  = (i == 1) ? 4'd1 : 4'd2;
      exp0 = ((i % 2) == 0);
      @(negedge clk);
      checks++;
      if (req0_ready !== exp0 || req1_ready !== !exp0) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d: got %b%b want %b%b", i, req0_ready, req1_ready, exp0, !exp0);
      end
      if (exp0) exp_q.push_back('{addr: req0_addr, data: req0_data});
      else      exp_q.push_back('{addr: req1_addr, data: req1_data});
      if (i > 0) begin
        checks++;
        if (rf_we !== 1'b1 || exp_q.size() < 2) begin
          errors++;
          $display("[TB] FAIL rr_commit_%0d: rf_we=%b queued=%0d want 1/2", i, rf_we, exp_q.size());
        end else begin
          exp_w = exp_q.pop_front();
          if (rf_waddr !== exp_w.addr || rf_wdata !== exp_w.data) begin
            errors++;
            $display("[TB] FAIL rr_commit_%0d: got %0d=%h want %0d=%h", i, rf_waddr, rf_wdata, exp_w.addr, exp_w.data);
          end
        end
      end
      step();
      if (exp0) req0_data = req0_data + 20'd1;
      else      req1_data = req1_data + 20'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; mark_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL rr_commit_last: rf_we=%b queued=%0d want 1/1", rf_we, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (rf_waddr !== exp_w.addr || rf_wdata !== exp_w.data) begin
        errors++;
        $display("[TB] FAIL rr_commit_last: got %0d=%h want %0d=%h", rf_waddr, rf_wdata, exp_w.addr, exp_w.data);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || pending !== '0 || err_unmarked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rr_idle: we=%b pending=%h err=%b want 0/0/0", rf_we, pending, err_unmarked);
    end
    step();
  endtask

  task automatic test_collision();
    mark_valid = 1'b1; mark_addr = 4'd7;
    step();
    mark_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 20'h07777;
    @(negedge clk);
    exp_q.push_back('{addr: req0_addr, data: req0_data});
    step();
    req0_valid = 1'b0;
    mark_valid = 1'b1; mark_addr = 4'd7;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL coll_commit: rf_we=%b queued=%0d want 1/1", rf_we, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (rf_waddr !== exp_w.addr || rf_wdata !== exp_w.data) begin
        errors++;
        $display("[TB] FAIL coll_commit: got %0d=%h want %0d=%h", rf_waddr, rf_wdata, exp_w.addr, exp_w.data);
      end
    end
    step();
    mark_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 20'h09999;
    @(negedge clk);
    checks++;
    if (pending[7] !== 1'b1 || err_unmarked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coll_set_wins: p7=%b err=%b want 1/0", pending[7], err_unmarked);
    end
    exp_q.push_back('{addr: req0_addr, data: req0_data});
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unmarked_commit: rf_we=%b queued=%0d want 1/1", rf_we, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (rf_waddr !== exp_w.addr || rf_wdata !== exp_w.data) begin
        errors++;
        $display("[TB] FAIL unmarked_commit: got %0d=%h want %0d=%h", rf_waddr, rf_wdata, exp_w.addr, exp_w.data);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (err_unmarked !== 1'b1) begin
        errors++;
        $display("[TB] FAIL err_sticky_%0d: got %b want 1", i, err_unmarked);
      end
    end
    step();
    do_reset();
    @(negedge clk);
    checks++;
    if (err_unmarked !== 1'b0 || pending !== '0) begin
      errors++;
      $display("[TB] FAIL err_reset: err=%b pending=%h want 0/0", err_unmarked, pending);
    end
    step();
  endtask

  task automatic test_reset_midop();
    mark_valid = 1'b1; mark_addr = 4'd3;
    step();
    mark_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 4'd3; req1_data = 20'h33333;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_accept: got %b%b want 01", req0_ready, req1_ready);
    end
    exp_q.push_back('{addr: req1_addr, data: req1_data});
    step();
    req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL midop_inflight: rf_we=%b queued=%0d want 1/1", rf_we, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (rf_waddr !== exp_w.addr || rf_wdata !== exp_w.data) begin
        errors++;
        $display("[TB] FAIL midop_inflight: got %0d=%h want %0d=%h", rf_waddr, rf_wdata, exp_w.addr, exp_w.data);
      end
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || pending[3] !== 1'b0 || pending !== '0) begin
      errors++;
      $display("[TB] FAIL midop_discard: we=%b p3=%b pending=%h want 0/0/0", rf_we, pending[3], pending);
    end
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d writes never seen, want 0", exp_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    wb_hold = 1'b0;
    mark_valid = 1'b0; mark_addr = '0;
    chk_addr0 = '0; chk_addr1 = '0;
    step();
    test_reset();
    test_single_write();
    test_hold_and_fairness();
    test_collision();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port arbiter and pending-write scoreboard for the 16-entry register bank (single write port, two read ports). It shares the one bank write port between two writeback requesters, the ALU and the load unit, using valid/ready handshakes and round-robin arbitration. It tracks which registers have an outstanding producer so the issue stage can detect read-after-write hazards on both read addresses.

Parameters:
WIDTH, 20, data word width; matches the register bank word.
AW, 4, register address width; depth = 2^AW = 16.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
req0_valid  input  1  requester 0 (ALU) has a write pending
req0_ready  output  1  requester 0 write accepted this cycle
req0_addr  input  AW  requester 0 destination register
req0_data  input  WIDTH  requester 0 write data
req1_valid  input  1  requester 1 (load unit) has a write pending
req1_ready  output  1  requester 1 write accepted this cycle
req1_addr  input  AW  requester 1 destination register
req1_data  input  WIDTH  requester 1 write data
wb_hold  input  1  suppresses all grants while high
rf_we  output  1  bank write enable (registered)
rf_waddr  output  AW  bank write address (registered)
rf_wdata  output  WIDTH  bank write data (registered)
mark_valid  input  1  issue stage declares a new producer
mark_addr  input  AW  register being marked pending
chk_addr0  input  AW  read address 0 to check
chk_addr1  input  AW  read address 1 to check
hazard0  output  1  chk_addr0 has an outstanding write
hazard1  output  1  chk_addr1 has an outstanding write
pending  output  2^AW  scoreboard bit vector
err_unmarked  output  1  sticky: a committed write targeted a non-pending register

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pending=0, err_unmarked=0.
  - Priority pointer points to requester 0.
- Ready during reset: req0_ready and req1_ready are 0 in any cycle where rst=1, so no handshake completes.
- Arbitration (combinational, same cycle):
  - If wb_hold=1 or rst=1: both ready=0.
  - Else if exactly one valid: that requester gets ready=1.
  - Else if both valid: the requester named by the pointer gets ready=1, the other 0.
  - A grant with valid=1 is an accept. Exactly one ready is high at most.
- Pointer update: after an accept, the pointer moves to the non-granted requester. With no accept, the pointer holds.
- Write output:
  - The accept in cycle N registers addr/data, giving rf_we=1 in cycle N+1; the bank captures at the end of N+1.
  - No accept gives rf_we=0 next cycle. rf_waddr/rf_wdata hold their last value when rf_we=0.
- Throughput: one write per cycle, back-to-back allowed.
- Scoreboard:
  - Set: a cycle with mark_valid=1 sets pending[mark_addr] at the edge.
  - Clear: a cycle with rf_we=1 clears pending[rf_waddr] at the edge.
  - Same address set and clear in one cycle: the set wins, and the bit stays 1 (new producer).
  - Set and clear on different addresses are both applied.
  - Marking an already pending register leaves it 1; there is no counting.
- Hazards:
  - hazard0 = pending[chk_addr0]; hazard1 = pending[chk_addr1]; both combinational.
  - The bit stays set through the rf_we cycle, so a read in that cycle sees a hazard because the bank still holds the old value.
  - The hazard drops the cycle after commit.
- err_unmarked: set at the edge when rf_we=1 and pending[rf_waddr]=0 (including the set-wins collision case evaluated before the update). Cleared only by rst.
- Reset mid-operation: an in-flight registered write is discarded (rf_we forced 0 next cycle). Requesters must re-present after reset.
- Requester rule: a requester must hold valid/addr/data stable until ready; the arbiter does not buffer.

Test Plan:
- Reset state: rst=1 for 2 cycles with req0_valid=1 -> ready=0, rf_we=0, pending=0, err_unmarked=0 throughout; first accept in the cycle after rst drops.
- Single write path: mark r5; next cycle req0 writes r5=0x12345 -> req0_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345, hazard0 (chk_addr0=5) still 1; following cycle pending[5]=0, hazard0=0.
- Round-robin fairness: both valid continuously for 4 cycles (req0→r1, req1→r2) -> grants alternate req0, req1, req0, req1; rf_we high 4 consecutive cycles.
- Hold: both valid with wb_hold=1 for 3 cycles -> no ready, rf_we=0, pointer unchanged; on release req0 is granted first after reset.
- Mark/commit collision: r7 pending, commit to r7 in the same cycle as mark_valid r7 -> pending[7] remains 1 and err_unmarked stays 0; commit to unmarked r9 -> err_unmarked=1 sticky until rst.
- Reset mid-op: accept req1 write r3 in cycle N, assert rst in N+1 -> no bank write visible after reset (rf_we=0 in N+2), pending[3]=0.
